// File: rtl/school_seating_system.sv
// school_seating_system: 32-entry seat table with owner/state/stamp per seat,
// a minute-of-day clock, owner-checked state transitions, automatic release of
// AWAY and RESERVED seats on timeout, and combinational readback.
module school_seating_system (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [24:0] Student_No,
  input  logic [4:0]  Seat_No,
  input  logic        write,
  output logic [10:0] Time,
  input  logic [1:0]  Seat_State,
  output logic        ack,
  output logic        err,
  output logic [24:0] rd_student,
  output logic [1:0]  rd_state
);

  localparam logic [1:0]  ST_EMPTY    = 2'b00;
  localparam logic [1:0]  ST_AWAY     = 2'b01;
  localparam logic [1:0]  ST_RESERVED = 2'b10;
  localparam logic [1:0]  ST_OCCUPIED = 2'b11;
  localparam logic [10:0] TIME_LAST   = 11'd1439;
  localparam logic [10:0] AWAY_LIMIT  = 11'd30;
  localparam logic [10:0] RES_LIMIT   = 11'd15;

  // Minutes since the stamp, modulo one day. The true result is always below
  // 1440, so the 11-bit wrap-around in the second branch is harmless.
  function automatic logic [10:0] elapsed_min(input logic [10:0] now,
                                              input logic [10:0] stamp);
    logic [10:0] result;
    if (now >= stamp) begin
      result = now - stamp;
    end else begin
      result = now + 11'd1440 - stamp;
    end
    return result;
  endfunction

  logic [24:0] owner_r [32];
  logic [1:0]  state_r [32];
  logic [10:0] stamp_r [32];
  logic [10:0] time_r;
  logic        ack_r;
  logic        err_r;

  logic [24:0] cur_owner_s;
  logic [1:0]  cur_state_s;
  logic        owns_other_s;
  logic        accept_s;
  logic [24:0] new_owner_s;
  logic [1:0]  new_state_s;
  logic [10:0] new_stamp_s;
  logic [31:0] timeout_s;

  assign cur_owner_s = owner_r[Seat_No];
  assign cur_state_s = state_r[Seat_No];

  // Does the requester already hold a non-empty seat somewhere in the table?
  always_comb begin
    owns_other_s = 1'b0;
    for (int i = 0; i < 32; i++) begin
      owns_other_s = owns_other_s |
                     ((state_r[i] != ST_EMPTY) && (owner_r[i] == Student_No));
    end
  end

  // Evaluate the request against the addressed entry and form its new contents.
  always_comb begin
    accept_s    = 1'b0;
    new_owner_s = cur_owner_s;
    new_state_s = cur_state_s;
    new_stamp_s = stamp_r[Seat_No];
    if (Student_No == 25'd0) begin
      accept_s = 1'b0;
    end else if (cur_state_s == ST_EMPTY) begin
      // An empty seat can only be claimed by someone not seated elsewhere.
      if (((Seat_State == ST_OCCUPIED) || (Seat_State == ST_RESERVED)) && !owns_other_s) begin
        accept_s    = 1'b1;
        new_owner_s = Student_No;
        new_state_s = Seat_State;
        new_stamp_s = time_r;
      end else begin
        accept_s = 1'b0;
      end
    end else if (cur_owner_s != Student_No) begin
      accept_s = 1'b0;
    end else if (Seat_State == cur_state_s) begin
      // Re-asserting the current state is accepted but must not refresh the stamp.
      accept_s = 1'b1;
    end else begin
      case ({cur_state_s, Seat_State})
        {ST_RESERVED, ST_OCCUPIED},
        {ST_OCCUPIED, ST_AWAY},
        {ST_AWAY,     ST_OCCUPIED}: begin
          accept_s    = 1'b1;
          new_state_s = Seat_State;
          new_stamp_s = time_r;
        end
        {ST_RESERVED, ST_EMPTY},
        {ST_OCCUPIED, ST_EMPTY},
        {ST_AWAY,     ST_EMPTY}: begin
          accept_s    = 1'b1;
          new_owner_s = 25'd0;
          new_state_s = ST_EMPTY;
        end
        default: begin
          accept_s = 1'b0;
        end
      endcase
    end
  end

  // Per-seat timeout detection, all seats in parallel.
  always_comb begin
    timeout_s = 32'd0;
    for (int i = 0; i < 32; i++) begin
      timeout_s[i] = ((state_r[i] == ST_AWAY)     && (elapsed_min(time_r, stamp_r[i]) >= AWAY_LIMIT)) ||
                     ((state_r[i] == ST_RESERVED) && (elapsed_min(time_r, stamp_r[i]) >= RES_LIMIT));
    end
  end

  // Minute counter, wrapping at the end of the day.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_r <= 11'd0;
    end else if (time_r == TIME_LAST) begin
      time_r <= 11'd0;
    end else begin
      time_r <= time_r + 11'd1;
    end
  end

  // Seat table update: an accepted write to a seat takes priority over its timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        owner_r[i] <= 25'd0;
        state_r[i] <= ST_EMPTY;
        stamp_r[i] <= 11'd0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (write && accept_s && (Seat_No == 5'(i))) begin
          owner_r[i] <= new_owner_s;
          state_r[i] <= new_state_s;
          stamp_r[i] <= new_stamp_s;
        end else if (timeout_s[i]) begin
          owner_r[i] <= 25'd0;
          state_r[i] <= ST_EMPTY;
        end else begin
          owner_r[i] <= owner_r[i];
          state_r[i] <= state_r[i];
        end
      end
    end
  end

  // One-cycle accept/reject pulses for each write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      ack_r <= write & accept_s;
      err_r <= write & ~accept_s;
    end
  end

  assign Time       = time_r;
  assign ack        = ack_r;
  assign err        = err_r;
  assign rd_state   = cur_state_s;
  assign rd_student = (cur_state_s == ST_EMPTY) ? 25'd0 : cur_owner_s;

endmodule

// File: tb/tb_school_seating_system.sv
// Bench for school_seating_system: a stimulus process drives requests and
// pushes the expected post-edge outputs from a behavioural seat model; a
// separate monitor pops and compares them each cycle the DUT presents them.
module tb_school_seating_system;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [24:0] Student_No = 25'd0;
  logic [4:0]  Seat_No = 5'd0;
  logic        write = 1'b0;
  logic [1:0]  Seat_State = 2'd0;
  logic [10:0] Time;
  logic        ack;
  logic        err;
  logic [24:0] rd_student;
  logic [1:0]  rd_state;

  school_seating_system dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Student_No (Student_No),
    .Seat_No    (Seat_No),
    .write      (write),
    .Time       (Time),
    .Seat_State (Seat_State),
    .ack        (ack),
    .err        (err),
    .rd_student (rd_student),
    .rd_state   (rd_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [10:0] tm;
    logic [1:0]  st;
    logic [24:0] stu;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: plain integer arrays, states 0 EMPTY 1 AWAY 2 RESERVED 3 OCCUPIED.
  int m_owner[32];
  int m_state[32];
  int m_stamp[32];
  int m_time;

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_owner[i] = 0;
      m_state[i] = 0;
      m_stamp[i] = 0;
    end
    m_time = 0;
  endtask

  // Apply one request to the model, push the expected response, advance one clock.
  task automatic drive(input bit w, input int sn, input int seat, input int req);
    bit   acc;
    bit   owns;
    bit   timed;
    int   cur;
    int   el;
    exp_t e;
    write      = w;
    Student_No = sn[24:0];
    Seat_No    = seat[4:0];
    Seat_State = req[1:0];
    acc  = 1'b0;
    owns = 1'b0;
    cur  = m_state[seat];
    if (w) begin
      if (sn == 0) begin
        acc = 1'b0;
      end else if (cur == 0) begin
        for (int i = 0; i < 32; i++)
          if (m_state[i] != 0 && m_owner[i] == sn) owns = 1'b1;
        acc = (req == 3 || req == 2) && !owns;
      end else if (m_owner[seat] != sn) begin
        acc = 1'b0;
      end else begin
        acc = (req == cur) || (req == 0) ||
              (cur == 2 && req == 3) || (cur == 3 && req == 1) || (cur == 1 && req == 3);
      end
    end
    for (int i = 0; i < 32; i++) begin
      el    = (m_time - m_stamp[i] + 1440) % 1440;
      timed = (m_state[i] == 1 && el >= 30) || (m_state[i] == 2 && el >= 15);
      if (timed && !(acc && i == seat)) begin
        m_state[i] = 0;
        m_owner[i] = 0;
      end
    end
    if (acc && req != cur) begin
      if (req == 0) begin
        m_owner[seat] = 0;
        m_state[seat] = 0;
      end else begin
        m_owner[seat] = sn;
        m_state[seat] = req;
        m_stamp[seat] = m_time;
      end
    end
    m_time = (m_time + 1) % 1440;
    e.ack = w && acc;
    e.err = w && !acc;
    e.tm  = 11'(m_time);
    e.st  = 2'(m_state[seat]);
    e.stu = 25'(m_owner[seat]);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare the outputs presented after each edge with the scoreboard.
  initial begin
    exp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("ack", ack, r.ack);
        check("err", err, r.err);
        check("ack_err_exclusive", ack & err, 0);
        check("time", Time, r.tm);
        check("rd_state", rd_state, r.st);
        check("rd_student", rd_student, r.stu);
      end
    end
  end

  initial begin
    int pool[4];
    bit pw;
    int ps, pseat, preq;
    model_reset();
    #1;
    check("reset_time", Time, 0);
    check("reset_ack", ack, 0);
    check("reset_err", err, 0);
    check("reset_rd_state", rd_state, 0);
    check("reset_rd_student", rd_student, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Occupy, conflict, double seating.
    repeat (4) drive(1'b1, 'h1FFFFFF, 1, 3);
    drive(1'b1, 'h1EC10F3, 1, 3);
    drive(1'b1, 'h1EC10F3, 2, 3);
    drive(1'b1, 'h1FFFFFF, 5, 3);
    drive(1'b0, 0, 5, 0);

    // Away timeout: still AWAY after 29 idle cycles, released on the 30th.
    drive(1'b1, 'h1FFFFFF, 1, 1);
    repeat (30) drive(1'b0, 0, 1, 0);

    // Reserved timeout.
    drive(1'b1, 'h0000ABC, 7, 2);
    repeat (16) drive(1'b0, 0, 7, 0);

    // Transition legality.
    drive(1'b1, 'h123, 9, 2);
    drive(1'b1, 'h123, 9, 3);
    drive(1'b1, 'h123, 9, 2);
    drive(1'b1, 'h123, 9, 1);
    drive(1'b1, 'h123, 9, 2);
    drive(1'b1, 'h123, 9, 0);
    drive(1'b1, 'h123, 9, 0);
    drive(1'b1, 'h123, 9, 1);
    drive(1'b1, 0, 9, 3);

    // Randomized traffic with a small student pool so conflicts are frequent.
    pool[0] = 0;
    pool[1] = 'h1;
    pool[2] = 'h2;
    pool[3] = 'h1ABCDE;
    pw = 1'b0; ps = 0; pseat = 0; preq = 0;
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        pw    = ($urandom_range(0, 3) != 0);
        ps    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 'h1FFFFFF)) : pool[$urandom_range(0, 3)];
        pseat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
        preq  = int'($urandom_range(0, 3));
      end
      drive(pw, ps, pseat, preq);
    end

    // Release every seat, then stamp an AWAY entry at 1430 across midnight.
    for (int s = 0; s < 32; s++)
      if (m_state[s] != 0) drive(1'b1, m_owner[s], s, 0);
    while (m_time != 1429) drive(1'b0, 0, $urandom_range(0, 31), 0);
    drive(1'b1, 'h155AA, 20, 3);
    drive(1'b1, 'h155AA, 20, 1);
    while (m_time != 22) drive(1'b0, 0, 20, 0);

    // Asynchronous reset in the middle of a write with several seats held.
    drive(1'b1, 'h11, 3, 3);
    drive(1'b1, 'h22, 4, 3);
    drive(1'b1, 'h33, 6, 2);
    write      = 1'b1;
    Student_No = 25'h44;
    Seat_No    = 5'd8;
    Seat_State = 2'd3;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_time", Time, 0);
    check("async_reset_ack", ack, 0);
    check("async_reset_err", err, 0);
    for (int s = 0; s < 32; s++) begin
      Seat_No = 5'(s);
      #1;
      check("async_reset_rd_state", rd_state, 0);
      check("async_reset_rd_student", rd_student, 0);
    end
    write = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b0, 0, 3, 0);
    drive(1'b1, 'h11, 3, 3);
    drive(1'b1, 'h44, 8, 3);

    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
